// File: rtl/instruction_fetch.sv
// Fetch stage: one outstanding instruction-memory read, a small circular queue
// toward decode, PC stall generation and jump-driven flush of stale fetches.
module instruction_fetch #(
    parameter int ADDR_WIDTH  = 16,
    parameter int INSTR_WIDTH = 16,
    parameter int DEPTH       = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [ADDR_WIDTH-1:0]  pc,
    input  logic                   jump_en,
    output logic                   pc_stall,
    output logic                   mem_req,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic                   mem_rvalid,
    input  logic [INSTR_WIDTH-1:0] mem_rdata,
    output logic                   instr_valid,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0]  instr_pc,
    input  logic                   decode_ready
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t                 r_state;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [CNT_W-1:0]       r_count;
    logic [ADDR_WIDTH-1:0]  r_req_pc;
    logic [ADDR_WIDTH-1:0]  r_q_pc    [DEPTH];
    logic [INSTR_WIDTH-1:0] r_q_instr [DEPTH];

    logic                   w_pop;
    logic                   w_push;
    logic                   w_issue;
    logic [CNT_W-1:0]       w_count_after;

    // Issue looks at the occupancy after this cycle's push/pop so a pop from a
    // full queue lets the next request go out in the same cycle.
    always_comb begin
        w_pop         = (r_count != '0) & decode_ready & ~jump_en;
        w_push        = mem_rvalid & (r_state == WAIT) & ~jump_en;
        w_count_after = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        w_issue       = reset & ~jump_en
                      & ((r_state == IDLE) | ((r_state == WAIT) & mem_rvalid))
                      & (w_count_after < CNT_W'(DEPTH));
    end

    assign mem_req     = w_issue;
    assign mem_addr    = pc;
    assign pc_stall    = ~w_issue;
    assign instr_valid = (r_count != '0);
    assign instr       = r_q_instr[r_rd_ptr];
    assign instr_pc    = r_q_pc[r_rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_req_pc <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_q_pc[PTR_W'(i)]    <= '0;
                r_q_instr[PTR_W'(i)] <= '0;
            end
        end else begin
            if (w_issue)
                r_req_pc <= pc;

            if (jump_en) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_q_pc[r_wr_ptr]    <= r_req_pc;
                    r_q_instr[r_wr_ptr] <= mem_rdata;
                    r_wr_ptr            <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_count <= w_count_after;
            end

            case (r_state)
                IDLE: begin
                    if (w_issue)
                        r_state <= WAIT;
                end
                WAIT: begin
                    if (jump_en)
                        r_state <= mem_rvalid ? IDLE : DISCARD;
                    else if (mem_rvalid)
                        r_state <= w_issue ? WAIT : IDLE;
                end
                DISCARD: begin
                    if (mem_rvalid)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: variable-latency memory, program-counter model and
// a queue-based reference of which instructions decode must see.
module tb_instruction_fetch;
    localparam int AW    = 16;
    localparam int IW    = 16;
    localparam int DEPTH = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] pc = '0;
    logic          jump_en = 1'b0;
    logic          pc_stall;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_rvalid = 1'b0;
    logic [IW-1:0] mem_rdata = '0;
    logic          instr_valid;
    logic [IW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          decode_ready = 1'b0;

    instruction_fetch #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .pc(pc), .jump_en(jump_en),
        .pc_stall(pc_stall), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .decode_ready(decode_ready)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [IW-1:0] d;
    } ent_t;

    // reference: fetched-not-consumed instructions, PC, outstanding read
    ent_t          mq[$];
    logic [AW-1:0] m_pc;
    bit            m_out;
    bit            m_stale;
    logic [AW-1:0] m_req_addr;
    // memory model
    bit            mem_pend;
    int            mem_cnt;
    logic [AW-1:0] mem_a;
    int            lat_lo = 1;
    int            lat_hi = 1;
    // observations of the DUT
    logic [AW-1:0] obs_addrs[$];
    int            obs_req_cyc[$];
    logic [AW-1:0] obs_deliv[$];
    int            obs_first_valid;
    int            obs_stalls;
    int            cyc;

    task automatic model_reset();
        mq.delete();
        m_pc = '0; m_out = 0; m_stale = 0; m_req_addr = '0;
        mem_pend = 0; mem_cnt = 0; mem_a = '0;
        obs_addrs.delete(); obs_req_cyc.delete(); obs_deliv.delete();
        obs_first_valid = -1; obs_stalls = 0; cyc = 0;
    endtask

    // Called at a falling edge; ends at the next falling edge.
    task automatic run_cycle(input bit jmp, input logic [AW-1:0] tgt, input bit rdy);
        bit rv, pop, push, iss;
        int after;
        rv = 0;
        if (mem_pend) begin
            mem_cnt--;
            if (mem_cnt == 0) begin rv = 1; mem_pend = 0; end
        end
        mem_rvalid   = rv;
        mem_rdata    = rv ? (mem_a + 16'h0100) : IW'($urandom);
        pc           = m_pc;
        jump_en      = jmp;
        decode_ready = rdy;
        #1;
        pop   = (mq.size() != 0) && rdy && !jmp;
        push  = rv && !m_stale && !jmp;
        after = mq.size() + int'(push) - int'(pop);
        iss   = !jmp && (!m_out || (rv && !m_stale)) && (after < DEPTH);

        total++;
        if (mem_req !== iss) begin
            bad++; $display("FAIL mem_req cyc=%0d got=%b want=%b", cyc, mem_req, iss);
        end
        total++;
        if (pc_stall !== !iss) begin
            bad++; $display("FAIL pc_stall cyc=%0d got=%b want=%b", cyc, pc_stall, !iss);
        end
        if (iss) begin
            total++;
            if (mem_addr !== m_pc) begin
                bad++; $display("FAIL mem_addr cyc=%0d got=%h want=%h", cyc, mem_addr, m_pc);
            end
        end
        total++;
        if (instr_valid !== (mq.size() != 0)) begin
            bad++; $display("FAIL instr_valid cyc=%0d got=%b want=%b", cyc, instr_valid, mq.size() != 0);
        end
        if (mq.size() != 0) begin
            total++;
            if (instr_pc !== mq[0].a || instr !== mq[0].d) begin
                bad++;
                $display("FAIL head cyc=%0d got pc=%h instr=%h want pc=%h instr=%h",
                         cyc, instr_pc, instr, mq[0].a, mq[0].d);
            end
        end

        if (mem_req === 1'b1) begin obs_addrs.push_back(mem_addr); obs_req_cyc.push_back(cyc); end
        if (pc_stall === 1'b1) obs_stalls++;
        if (instr_valid === 1'b1 && obs_first_valid < 0) obs_first_valid = cyc;
        if (instr_valid === 1'b1 && rdy && !jmp) obs_deliv.push_back(instr_pc);

        if (jmp) begin
            mq.delete();
            if (m_out) begin
                if (rv) begin m_out = 0; m_stale = 0; end
                else m_stale = 1;
            end
            m_pc = tgt;
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(ent_t'{a: m_req_addr, d: mem_rdata});
            if (rv) begin m_out = 0; m_stale = 0; end
            if (iss) begin
                m_out = 1; m_req_addr = m_pc;
                mem_pend = 1; mem_a = m_pc; mem_cnt = $urandom_range(lat_hi, lat_lo);
                m_pc = m_pc + 1'b1;
            end
        end
        cyc++;
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b0; jump_en = 0; decode_ready = 0; mem_rvalid = 0; pc = '0;
        repeat (2) @(negedge clock);
        model_reset();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; jump_en = 0; decode_ready = 1; mem_rvalid = 0; pc = 16'h0033;
        repeat (2) @(negedge clock);
        #1;
        total++;
        if (instr_valid !== 1'b0 || instr !== '0 || instr_pc !== '0) begin
            bad++; $display("FAIL reset_queue valid=%b instr=%h pc=%h want 0/0/0", instr_valid, instr, instr_pc);
        end
        total++;
        if (mem_req !== 1'b0 || pc_stall !== 1'b1) begin
            bad++; $display("FAIL reset_req mem_req=%b pc_stall=%b want 0/1", mem_req, pc_stall);
        end
    endtask

    task automatic test_stream();
        do_reset();
        lat_lo = 1; lat_hi = 1;
        for (int i = 0; i < 20; i++) run_cycle(0, '0, 1);
        total++;
        if (obs_req_cyc.size() != 20 || obs_stalls != 0) begin
            bad++; $display("FAIL stream_reqs got reqs=%0d stalls=%0d want 20/0", obs_req_cyc.size(), obs_stalls);
        end
        total++;
        if (obs_req_cyc.size() == 0 || obs_first_valid != obs_req_cyc[0] + 2) begin
            bad++; $display("FAIL stream_latency got first_valid=%0d want first_req+2", obs_first_valid);
        end
        total++;
        if (obs_deliv.size() != 18) begin
            bad++; $display("FAIL stream_count got=%0d want=18", obs_deliv.size());
        end
        for (int i = 0; i < obs_deliv.size(); i++) begin
            total++;
            if (obs_deliv[i] !== AW'(i)) begin
                bad++; $display("FAIL stream_order idx=%0d got=%h want=%h", i, obs_deliv[i], AW'(i));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        lat_lo = 1; lat_hi = 1;
        for (int i = 0; i < 6; i++) run_cycle(0, '0, 0);
        decode_ready = 0; pc = m_pc; #1;
        total++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h0000 || mem_req !== 1'b0 || pc_stall !== 1'b1) begin
            bad++; $display("FAIL bp_full valid=%b pc=%h req=%b stall=%b want 1/0000/0/1",
                            instr_valid, instr_pc, mem_req, pc_stall);
        end
        total++;
        if (obs_addrs.size() != 2) begin
            bad++; $display("FAIL bp_reqs got=%0d want=2", obs_addrs.size());
        end
        #1;
        for (int i = 0; i < 10; i++) run_cycle(0, '0, 1);
        total++;
        if (obs_req_cyc.size() < 3 || obs_req_cyc[2] != 6) begin
            bad++; $display("FAIL bp_resume third req cycle got=%0d want=6",
                            (obs_req_cyc.size() < 3) ? -1 : obs_req_cyc[2]);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (obs_deliv.size() <= i || obs_deliv[i] !== AW'(i)) begin
                bad++; $display("FAIL bp_order idx=%0d got=%h want=%h", i,
                                (obs_deliv.size() > i) ? obs_deliv[i] : 16'hxxxx, AW'(i));
            end
        end
    endtask

    task automatic test_latency3();
        do_reset();
        lat_lo = 4; lat_hi = 4;   // three idle cycles between request and data
        for (int i = 0; i < 24; i++) run_cycle(0, '0, 1);
        total++;
        if (obs_addrs.size() != 6) begin
            bad++; $display("FAIL lat_reqs got=%0d want=6", obs_addrs.size());
        end
        for (int i = 0; i < obs_addrs.size(); i++) begin
            total++;
            if (obs_addrs[i] !== AW'(i) || obs_req_cyc[i] != 4 * i) begin
                bad++; $display("FAIL lat_req idx=%0d got addr=%h cyc=%0d want addr=%h cyc=%0d",
                                i, obs_addrs[i], obs_req_cyc[i], AW'(i), 4 * i);
            end
        end
        total++;
        if (obs_deliv.size() != 5) begin
            bad++; $display("FAIL lat_count got=%0d want=5", obs_deliv.size());
        end
        for (int i = 0; i < obs_deliv.size(); i++) begin
            total++;
            if (obs_deliv[i] !== AW'(i)) begin
                bad++; $display("FAIL lat_order idx=%0d got=%h want=%h", i, obs_deliv[i], AW'(i));
            end
        end
    endtask

    task automatic test_jump_outstanding();
        int na, nd, jc, guard;
        bit hit;
        do_reset();
        lat_lo = 4; lat_hi = 4;
        hit = 0;
        for (guard = 0; guard < 100 && !hit; guard++) begin
            run_cycle(0, '0, 1);
            if (obs_req_cyc.size() != 0 && obs_req_cyc[$] == cyc - 1 && obs_addrs[$] == 16'h0005) hit = 1;
        end
        total++;
        if (!hit) begin
            bad++; $display("FAIL jo_setup got no request for 0005 want one within 100 cycles");
        end
        na = obs_addrs.size(); nd = obs_deliv.size(); jc = cyc;
        run_cycle(1, 16'h0010, 1);
        total++;
        if (instr_valid !== 1'b0) begin
            bad++; $display("FAIL jo_flush instr_valid got=%b want=0", instr_valid);
        end
        for (int i = 0; i < 16; i++) run_cycle(0, '0, 1);
        total++;
        if (obs_addrs.size() <= na || obs_addrs[na] !== 16'h0010 || obs_req_cyc[na] != jc + 4) begin
            bad++; $display("FAIL jo_next_req got addr=%h cyc=%0d want addr=0010 cyc=%0d",
                            (obs_addrs.size() > na) ? obs_addrs[na] : 16'hxxxx,
                            (obs_addrs.size() > na) ? obs_req_cyc[na] : -1, jc + 4);
        end
        total++;
        if (obs_deliv.size() <= nd || obs_deliv[nd] !== 16'h0010) begin
            bad++; $display("FAIL jo_first_deliv got=%h want=0010",
                            (obs_deliv.size() > nd) ? obs_deliv[nd] : 16'hxxxx);
        end
    endtask

    task automatic test_jump_full();
        int jc, nd;
        bit hit;
        do_reset();
        lat_lo = 4; lat_hi = 4;
        hit = 0;
        for (int guard = 0; guard < 60 && !hit; guard++) begin
            if (mem_pend && mem_cnt == 1 && mq.size() == 1) hit = 1;
            else run_cycle(0, '0, 0);
        end
        total++;
        if (!hit) begin
            bad++; $display("FAIL jf_setup got no fill point want one within 60 cycles");
        end
        jc = cyc; nd = obs_deliv.size();
        run_cycle(1, 16'h0040, 0);
        total++;
        if (instr_valid !== 1'b0) begin
            bad++; $display("FAIL jf_flush instr_valid got=%b want=0", instr_valid);
        end
        for (int i = 0; i < 8; i++) run_cycle(0, '0, 1);
        total++;
        if (obs_req_cyc.size() < 3 || obs_req_cyc[2] != jc + 1 || obs_addrs[2] !== 16'h0040) begin
            bad++; $display("FAIL jf_next_req got cyc=%0d addr=%h want cyc=%0d addr=0040",
                            (obs_req_cyc.size() > 2) ? obs_req_cyc[2] : -1,
                            (obs_addrs.size() > 2) ? obs_addrs[2] : 16'hxxxx, jc + 1);
        end
        total++;
        if (obs_deliv.size() <= nd || obs_deliv[nd] !== 16'h0040) begin
            bad++; $display("FAIL jf_first_deliv got=%h want=0040",
                            (obs_deliv.size() > nd) ? obs_deliv[nd] : 16'hxxxx);
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        lat_lo = 1; lat_hi = 1;
        for (int i = 0; i < 5; i++) run_cycle(0, '0, 0);
        decode_ready = 0; jump_en = 0; mem_rvalid = 0; pc = m_pc;
        #1;
        total++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h0000) begin
            bad++; $display("FAIL mr_before valid=%b pc=%h want 1/0000", instr_valid, instr_pc);
        end
        #1 reset = 1'b0;
        #1;
        total++;
        if (instr_valid !== 1'b0 || mem_req !== 1'b0 || pc_stall !== 1'b1) begin
            bad++; $display("FAIL mr_async valid=%b req=%b stall=%b want 0/0/1", instr_valid, mem_req, pc_stall);
        end
        do_reset();
        for (int i = 0; i < 6; i++) run_cycle(0, '0, 1);
        total++;
        if (obs_addrs.size() == 0 || obs_addrs[0] !== 16'h0000 || obs_req_cyc[0] != 0) begin
            bad++; $display("FAIL mr_restart got addr=%h want 0000 at cycle 0",
                            (obs_addrs.size() > 0) ? obs_addrs[0] : 16'hxxxx);
        end
        total++;
        if (obs_deliv.size() == 0 || obs_deliv[0] !== 16'h0000) begin
            bad++; $display("FAIL mr_first_deliv got=%h want=0000",
                            (obs_deliv.size() > 0) ? obs_deliv[0] : 16'hxxxx);
        end
    endtask

    task automatic test_random();
        do_reset();
        lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 400; i++) begin
            bit j;
            j = ($urandom_range(0, 14) == 0);
            run_cycle(j, AW'($urandom), $urandom_range(0, 3) != 0);
        end
        total++;
        if (obs_deliv.size() < 20) begin
            bad++; $display("FAIL rand_progress delivered=%0d want>=20", obs_deliv.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_backpressure();
        test_latency3();
        test_jump_outstanding();
        test_jump_full();
        test_reset_midstream();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
